fmul_stage2: RTL

FMUL_STAGE2 -- requirements
Module: fmul_stage2

---
 rtl/fmul_stage2.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fmul_stage2.sv
// rtl/fmul_stage2.sv - single-precision multiply core: shift-add mantissa product, exponent add, normalise
// Special cases arrive pre-resolved from the classifier and bypass the multiplier.
module fmul_stage2 #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A_exp,
  input  logic [7:0]  B_exp,
  input  logic [22:0] A_frac,
  input  logic [22:0] B_frac,
  input  logic        sign,
  input  logic        primal,
  input  logic [7:0]  primal_exp,
  input  logic [23:0] primal_frac,
  input  logic        error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_frac,
  output logic        out_error,
  output logic        out_overflow,
  output logic        out_underflow
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state, state_n;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] acc;
  logic [4:0]  cnt;
  logic [7:0]  a_exp_r, b_exp_r;
  logic        sign_r;

  logic [9:0]  e_raw;
  logic [22:0] norm_frac;
  logic        e_ovf, e_unf;
  logic        unused_primal_lsb;

  // primal_frac carries one guard bit below the packed fraction; it is dropped.
  assign unused_primal_lsb = primal_frac[0];

  // Two's-complement wrap in 10 bits yields the signed exponent directly.
  assign e_raw = {2'b00, a_exp_r} + {2'b00, b_exp_r} - 10'(EXP_BIAS) + {9'd0, acc[47]};
  assign e_ovf = $signed(e_raw) >= 10'sd255;
  assign e_unf = $signed(e_raw) <= 10'sd0;
  assign norm_frac = acc[47] ? acc[46:24] : acc[45:23];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = primal ? DONE : MUL;
      MUL:  if (cnt == 5'd23) state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      a_exp_r       <= '0;
      b_exp_r       <= '0;
      sign_r        <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_frac      <= '0;
      out_error     <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r  <= sign;
            a_exp_r <= A_exp;
            b_exp_r <= B_exp;
            if (primal) begin
              out_sign      <= sign;
              out_exp       <= primal_exp;
              out_frac      <= primal_frac[23:1];
              out_error     <= error;
              out_overflow  <= 1'b0;
              out_underflow <= 1'b0;
            end else begin
              mcand  <= {24'd0, 1'b1, A_frac};
              mplier <= {1'b1, B_frac};
              acc    <= '0;
              cnt    <= '0;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        NORM: begin
          out_sign  <= sign_r;
          out_error <= 1'b0;
          if (e_ovf) begin
            out_exp       <= 8'hFF;
            out_frac      <= '0;
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
          end else if (e_unf) begin
            out_exp       <= 8'h00;
            out_frac      <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b1;
          end else begin
            out_exp       <= e_raw[7:0];
            out_frac      <= norm_frac;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
